// File: rtl/reaction_timer.sv
// reaction_timer: timing datapath for the reaction-time test.
//   - two ms wait timers (random wait, fixed penalty wait) on a shared prescaler
//   - exact ms stopwatch with sticky late flag
//   - result capture: last / best, plus optional 4-deep running average
// Optional feature macro: REACTION_AVG_EN (average of last four results).

// One request/done wait timer; counts ms ticks while its request is high.
module rt_wait_timer #(
  parameter int CW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req,
  input  logic          i_tick,
  input  logic [CW-1:0] i_target,
  output logic          o_done
);
  logic          r_req_q;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_tgt;
  logic          r_done;
  logic          w_rise;
  logic          w_hit;

  assign w_rise = i_req & ~r_req_q;
  assign w_hit  = (r_cnt >= r_tgt);

  // Latch target on request edge, count ticks, flag done one cycle after reaching it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req_q <= 1'b0;
      r_cnt   <= '0;
      r_tgt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_req_q <= i_req;
      if (w_rise) begin
        r_tgt <= i_target;
        r_cnt <= '0;
      end else if (i_req && i_tick && !w_hit) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // Rise cycle still sees the previous count/target, so mask it.
      r_done <= i_req & ~w_rise & w_hit;
    end
  end

  assign o_done = r_done;
endmodule

module reaction_timer #(
  parameter int CLK_PER_MS       = 100000,
  parameter int RWAIT_MIN_MS     = 1000,
  parameter int RWAIT_RANGE_BITS = 12,
  parameter int WAIT5_MS         = 5000,
  parameter int LATE_MS          = 1000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start_rwait,
  input  logic        i_start_wait5,
  input  logic        i_time_clr,
  input  logic        i_time_en,
  input  logic        i_rs_en,
  output logic        o_rwait_done,
  output logic        o_wait5_done,
  output logic        o_time_late,
  output logic [13:0] o_rt_ms,
  output logic [13:0] o_last_ms,
  output logic [13:0] o_best_ms,
  output logic [13:0] o_avg_ms,
  output logic        o_result_valid
);
  localparam int          PW       = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0] PMAX   = PW'(CLK_PER_MS - 1);
  localparam int          CW       = 16;
  localparam int          NUM_WAIT = 2;
  localparam logic [13:0] RT_MAX   = 14'd9999;
  localparam logic [13:0] LATE_Q   = 14'(LATE_MS);
  localparam logic [15:0] SEED     = 16'hACE1;

  // ---------------- wait prescaler + LFSR ----------------
  logic [PW-1:0] r_wpre;
  logic          w_wait_tick;
  logic [15:0]   r_lfsr;
  logic          w_lfsr_fb;

  assign w_wait_tick = (r_wpre == PMAX);
  assign w_lfsr_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  // Free-running ms prescaler shared by the wait timers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)         r_wpre <= '0;
    else if (w_wait_tick) r_wpre <= '0;
    else                  r_wpre <= r_wpre + 1'b1;
  end

  // Maximal-length LFSR; nonzero seed keeps it out of the all-zero lock-up state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_lfsr <= SEED;
    else          r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
  end

  // ---------------- wait timers (lane 0 random, lane 1 penalty) ----------------
  logic [NUM_WAIT-1:0]         w_req;
  logic [NUM_WAIT-1:0]         w_done;
  logic [NUM_WAIT-1:0][CW-1:0] w_tgt;

  assign w_req    = {i_start_wait5, i_start_rwait};
  assign w_tgt[0] = CW'(RWAIT_MIN_MS)
                  + {{(CW-RWAIT_RANGE_BITS){1'b0}}, r_lfsr[RWAIT_RANGE_BITS-1:0]};
  assign w_tgt[1] = CW'(WAIT5_MS);

  genvar g;
  generate
    for (g = 0; g < NUM_WAIT; g++) begin : g_wait
      rt_wait_timer #(.CW(CW)) u_wait (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_req    (w_req[g]),
        .i_tick   (w_wait_tick),
        .i_target (w_tgt[g]),
        .o_done   (w_done[g])
      );
    end
  endgenerate

  assign o_rwait_done = w_done[0];
  assign o_wait5_done = w_done[1];

  // ---------------- stopwatch ----------------
  logic [PW-1:0] r_spre;
  logic [13:0]   r_rt;
  logic          r_late;
  logic          w_sw_wrap;
  logic [13:0]   w_rt_inc;

  assign w_sw_wrap = (r_spre == PMAX);
  assign w_rt_inc  = (r_rt == RT_MAX) ? r_rt : r_rt + 14'd1;

  // Clear wins over run; late flag tracks the value rt is about to take.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_spre <= '0;
      r_rt   <= '0;
      r_late <= 1'b0;
    end else if (i_time_clr) begin
      r_spre <= '0;
      r_rt   <= '0;
      r_late <= 1'b0;
    end else if (i_time_en) begin
      if (w_sw_wrap) begin
        r_spre <= '0;
        r_rt   <= w_rt_inc;
        r_late <= r_late | (w_rt_inc >= LATE_Q);
      end else begin
        r_spre <= r_spre + 1'b1;
      end
    end
  end

  assign o_rt_ms     = r_rt;
  assign o_time_late = r_late;

  // ---------------- capture ----------------
  logic        r_rs_q;
  logic        r_rs_edge;
  logic [13:0] r_last;
  logic [13:0] r_best;
  logic        r_valid;

  // Registered rising-edge pulse, then capture of the current stopwatch value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rs_q    <= 1'b0;
      r_rs_edge <= 1'b0;
      r_last    <= '0;
      r_best    <= RT_MAX;
      r_valid   <= 1'b0;
    end else begin
      r_rs_q    <= i_rs_en;
      r_rs_edge <= i_rs_en & ~r_rs_q;
      if (r_rs_edge) begin
        r_last <= r_rt;
        if (r_rt < r_best) r_best <= r_rt;
      end
      // A coincident clear leaves the flag low even though the capture happens.
      if (i_time_clr)     r_valid <= 1'b0;
      else if (r_rs_edge) r_valid <= 1'b1;
    end
  end

  assign o_last_ms      = r_last;
  assign o_best_ms      = r_best;
  assign o_result_valid = r_valid;

`ifdef REACTION_AVG_EN
  logic [3:0][13:0] r_hist;
  logic             r_cap_d;
  logic [13:0]      r_avg;
  logic [15:0]      w_sum;

  assign w_sum = {2'b00, r_hist[0]} + {2'b00, r_hist[1]}
               + {2'b00, r_hist[2]} + {2'b00, r_hist[3]};

  // History shifts with each capture; average follows one cycle later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hist  <= '0;
      r_cap_d <= 1'b0;
      r_avg   <= '0;
    end else begin
      r_cap_d <= r_rs_edge;
      if (r_rs_edge) r_hist <= {r_hist[2:0], r_rt};
      if (r_cap_d)   r_avg  <= 14'(w_sum >> 2);
    end
  end

  assign o_avg_ms = r_avg;
`else
  assign o_avg_ms = '0;
`endif

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer with small timing parameters (10 clk/ms).
module tb_reaction_timer;
  localparam int C = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_rwait, start_wait5, time_clr, time_en, rs_en;
  logic        rwait_done, wait5_done, time_late, result_valid;
  logic [13:0] rt_ms, last_ms, best_ms, avg_ms;
  logic [15:0] m_lfsr;
  int          n_checks = 0;
  int          n_err    = 0;

  reaction_timer #(
    .CLK_PER_MS(C), .RWAIT_MIN_MS(2), .RWAIT_RANGE_BITS(2), .WAIT5_MS(3), .LATE_MS(5)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_start_rwait(start_rwait), .i_start_wait5(start_wait5),
    .i_time_clr(time_clr), .i_time_en(time_en), .i_rs_en(rs_en),
    .o_rwait_done(rwait_done), .o_wait5_done(wait5_done), .o_time_late(time_late),
    .o_rt_ms(rt_ms), .o_last_ms(last_ms), .o_best_ms(best_ms), .o_avg_ms(avg_ms),
    .o_result_valid(result_valid)
  );

  always #5 clk = ~clk;

  // Reference LFSR (taps 16,14,13,11, seed ACE1) to know which target gets latched.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run(input int n);
    time_en = 1'b1;
    repeat (n) @(negedge clk);
    time_en = 1'b0;
  endtask

  task automatic clr_pulse();
    time_clr = 1'b1;
    @(negedge clk);
    time_clr = 1'b0;
  endtask

  task automatic capture();
    rs_en = 1'b1;
    repeat (3) @(negedge clk);
    rs_en = 1'b0;
    @(negedge clk);
  endtask

  // Raise start_rwait and check done latency against the bound for N = 2 + lfsr[1:0].
  task automatic do_rwait(input string tag);
    int n;
    int k;
    bit seen;
    start_rwait = 1'b1;
    n    = 2 + int'(m_lfsr[1:0]);
    seen = 1'b0;
    k    = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (rwait_done) begin
        seen = 1'b1;
        k    = i;
        break;
      end
    end
    chk({tag, "_seen"}, 32'(seen), 1);
    chk({tag, "_lat_lo"}, 32'(k >= (n - 1) * C + 2), 1);
    chk({tag, "_lat_hi"}, 32'(k <= n * C + 2), 1);
  endtask

  initial begin
    int  w5;
    bit  flag;
    rst_n = 1'b0; start_rwait = 1'b0; start_wait5 = 1'b0;
    time_clr = 1'b0; time_en = 1'b0; rs_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rt", 32'(rt_ms), 0);
    chk("rst_best", 32'(best_ms), 9999);
    chk("rst_last", 32'(last_ms), 0);
    chk("rst_valid", 32'(result_valid), 0);
    rst_n = 1'b1;
    #1 chk("rst_lfsr", 32'(dut.r_lfsr), 32'h0000ACE1);

    // ---- random wait ----
    @(negedge clk);
    do_rwait("rw1");
    repeat (3) @(negedge clk);
    chk("rw1_hold", 32'(rwait_done), 1);
    start_rwait = 1'b0;
    @(negedge clk);
    chk("rw1_drop", 32'(rwait_done), 0);

    start_rwait = 1'b1;
    repeat (5) @(negedge clk);
    start_rwait = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rwait_done) flag = 1'b1;
    end
    chk("rw_abort", 32'(flag), 0);

    do_rwait("rw2");
    start_rwait = 1'b0;
    @(negedge clk);
    chk("rw2_drop", 32'(rwait_done), 0);

    // ---- stopwatch ----
    clr_pulse();
    run(245);
    chk("sw_24", 32'(rt_ms), 24);
    repeat (20) @(negedge clk);
    chk("sw_hold", 32'(rt_ms), 24);
    chk("sw_late", 32'(time_late), 1);
    clr_pulse();
    chk("sw_clr", 32'(rt_ms), 0);
    chk("sw_clr_late", 32'(time_late), 0);

    // ---- late flag ----
    time_en = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rt_ms < 14'd5 && time_late) flag = 1'b1;
      if (rt_ms == 14'd5) break;
    end
    chk("late_rt5", 32'(rt_ms), 5);
    chk("late_early", 32'(flag), 0);
    chk("late_at5", 32'(time_late), 1);
    repeat (40) @(negedge clk);
    time_en = 1'b0;
    chk("late_rt9", 32'(rt_ms), 9);
    chk("late_sticky", 32'(time_late), 1);
    clr_pulse();
    chk("late_clr", 32'(time_late), 0);

    // ---- capture ----
    run(240);
    rs_en = 1'b1;
    @(negedge clk);
    chk("cap_lat1", 32'(last_ms), 0);
    @(negedge clk);
    chk("cap1_last", 32'(last_ms), 24);
    chk("cap1_best", 32'(best_ms), 24);
    chk("cap1_valid", 32'(result_valid), 1);
    rs_en = 1'b0;
    @(negedge clk);
    run(60);
    capture();
    chk("cap2_last", 32'(last_ms), 30);
    chk("cap2_best", 32'(best_ms), 24);
    rs_en = 1'b1;
    repeat (3) @(negedge clk);
    run(50);
    repeat (3) @(negedge clk);
    chk("cap_held", 32'(last_ms), 30);
    rs_en = 1'b0;
    @(negedge clk);

    // ---- average + concurrent penalty wait ----
    clr_pulse();
    chk("avg_clr_valid", 32'(result_valid), 0);
    start_wait5 = 1'b1;
    time_en = 1'b1;
    w5 = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (wait5_done && w5 == 0) w5 = i;
    end
    time_en = 1'b0;
    chk("w5_lat_lo", 32'(w5 >= 21), 1);
    chk("w5_lat_hi", 32'(w5 <= 32), 1);
    chk("w5_hold", 32'(wait5_done), 1);
    capture();
    run(200);
    capture();
    run(200);
    capture();
    run(200);
    capture();
    chk("avg_last", 32'(last_ms), 80);
    chk("avg_best", 32'(best_ms), 20);
    chk("avg_valid", 32'(result_valid), 1);
`ifdef REACTION_AVG_EN
    chk("avg_val", 32'(avg_ms), 50);
`else
    chk("avg_off", 32'(avg_ms), 0);
`endif
    start_wait5 = 1'b0;
    @(negedge clk);
    chk("w5_drop", 32'(wait5_done), 0);

    // capture coincident with clear: pre-clear value captured, valid cleared
    run(50);
    rs_en = 1'b1;
    @(negedge clk);
    time_clr = 1'b1;
    @(negedge clk);
    time_clr = 1'b0;
    rs_en = 1'b0;
    chk("coinc_last", 32'(last_ms), 85);
    chk("coinc_valid", 32'(result_valid), 0);
    chk("coinc_rt", 32'(rt_ms), 0);

    // ---- reset mid-stopwatch ----
    run(370);
    chk("pre_rst_rt", 32'(rt_ms), 37);
    time_en = 1'b1;
    start_wait5 = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst2_rt", 32'(rt_ms), 0);
    chk("rst2_last", 32'(last_ms), 0);
    chk("rst2_best", 32'(best_ms), 9999);
    chk("rst2_late", 32'(time_late), 0);
    chk("rst2_avg", 32'(avg_ms), 0);
    chk("rst2_done", 32'({rwait_done, wait5_done}), 0);
    time_en = 1'b0;
    start_wait5 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst2_lfsr", 32'(dut.r_lfsr), 32'h0000ACE1);
    repeat (5) @(negedge clk);
    chk("post_rst_rt", 32'(rt_ms), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
